memory_bus_waitstate: RTL and testbench
=======================================

Name: memory_bus_waitstate

Overview:
- Parametrised successor to the CPU memory bus router. Decodes the top BANK_BITS of the CPU address into 2**BANK_BITS banks.
- Inserts per-bank programmable wait states and, per bank, optionally waits on an external ready, so slow SPI EEPROM/flash banks can stall the CPU.
- Returns a one-cycle ready pulse, registered read data, and bus_error for unmapped banks or ready timeouts.
- Sits between the CPU core and the RAM/ROM/peripheral/SPI bank instances.

Parameters:
- ADDR_WIDTH, 16, CPU address width.
- DATA_WIDTH, 8, data width.
- BANK_BITS, 2, number of address MSBs used for bank decode; NUM_BANKS = 2**BANK_BITS.
- BANK_PRESENT, 4'b1111, bit i = 1 if bank i is mapped.
- BANK_WAIT, 16'h1111, 4 bits per bank: wait-state count W(i), 0..15, bank i in bits [4i+3:4i].
- BANK_EXT_READY, 4'b0000, bit i = 1 if bank i must also see bank_ready[i].
- TIMEOUT_CYCLES, 255, maximum cycles in EXT_WAIT before error; 0 disables the timeout.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- address  input  ADDR_WIDTH  CPU address
- data_in  input  DATA_WIDTH  CPU write data
- data_out  output  DATA_WIDTH  registered read data to CPU
- bus_enable  input  1  CPU access request
- write_enable  input  1  1 = write, 0 = read
- ready  output  1  one-cycle access-complete pulse
- bus_error  output  1  valid with ready; unmapped bank or timeout
- err_address  output  ADDR_WIDTH  address of the most recent errored access
- bank_address  output  ADDR_WIDTH-BANK_BITS  latched in-bank address
- bank_data_out  output  DATA_WIDTH  latched write data to banks
- bank_enable  output  NUM_BANKS  one-hot bank select
- bank_write_enable  output  NUM_BANKS  one-hot write strobe
- bank_data_in  input  NUM_BANKS*DATA_WIDTH  read data; bank i in slice [i*DATA_WIDTH +: DATA_WIDTH]
- bank_ready  input  NUM_BANKS  external ready per bank

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE; wait and timeout counters clear.
  - data_out, ready, bus_error, err_address, bank_address, bank_data_out, bank_enable and bank_write_enable all go to 0.
- Reset mid-access: strobes drop immediately and the access is discarded; no ready is issued.
- States: IDLE, ACCESS, EXT_WAIT, DONE.
- IDLE, on an edge with bus_enable = 1:
  - Latch bank b = address[MSBs], the in-bank address, data_in and write_enable.
  - If BANK_PRESENT[b] = 0: go to DONE with ready = 1, bus_error = 1, data_out = 0, err_address = address. No bank strobes are asserted.
  - Otherwise: load counter = W(b) and go to ACCESS.
- ACCESS:
  - bank_enable[b] = 1; bank_write_enable[b] = latched write_enable.
  - If counter != 0: decrement.
  - If counter == 0 and BANK_EXT_READY[b] = 0: complete.
  - If counter == 0 and BANK_EXT_READY[b] = 1: complete this cycle if bank_ready[b] = 1, else go to EXT_WAIT and clear the timeout counter.
- EXT_WAIT:
  - Strobes stay held.
  - On bank_ready[b] = 1: complete.
  - Else increment the timeout counter. When it reaches TIMEOUT_CYCLES (if nonzero): go to DONE with ready = 1, bus_error = 1, err_address = latched address, data_out = 0.
- Complete:
  - On a read, data_out <= bank_data_in slice b; on a write, data_out is unchanged.
  - ready <= 1, bus_error <= 0, strobes deassert, go to DONE.
- DONE:
  - ready and bus_error are high for exactly one cycle, then 0.
  - Stay in DONE while bus_enable = 1 (one access per request). Return to IDLE once bus_enable = 0.
- Latency, mapped bank without ext ready: ready is high in the cycle following edge E0+1+W, where E0 is the edge that sampled bus_enable. Synchronous-RAM banks require W >= 1.
- CPU inputs are sampled only in IDLE. Changes to them during an access are ignored. Dropping bus_enable mid-access does not abort the access.
- bank_address and bank_data_out hold their last value between accesses.
- Counters saturate and never wrap. The timeout counter width is ceil(log2(TIMEOUT_CYCLES+1)).
- A bank_ready pulse outside ACCESS/EXT_WAIT, or for a non-selected bank, is ignored.

Test Plan:
- Read bank 0 with W = 1, address 0x0123, bank_data_in[7:0] = 0xA5 -> bank_enable = 0001 and bank_address = 0x123; ready pulses once 3 edges after the request with data_out = 0xA5 and bus_error = 0.
- Write 0x5A to 0xC010 with W = 3 -> bank_write_enable = 1000 held for exactly 4 cycles, bank_data_out = 0x5A; ready pulses once; data_out is unchanged.
- BANK_PRESENT = 4'b1011, access 0x8000 -> no strobes; ready = 1 and bus_error = 1 on the next cycle; err_address = 0x8000; data_out = 0.
- BANK_EXT_READY[1] = 1, read 0x4000, bank_ready[1] raised after 10 cycles with data 0x3C -> ready follows with data_out = 0x3C. Repeat with TIMEOUT_CYCLES = 8 and no bank_ready -> bus_error = 1 after 8 EXT_WAIT cycles.
- Hold bus_enable high for 20 cycles on one read -> exactly one ready pulse; new access starts only after a bus_enable low cycle.
- Assert reset during EXT_WAIT -> bank_enable = 0 immediately, no ready; the next access proceeds normally.

Source files
------------

// File: rtl/memory_bus_waitstate.sv
// memory_bus_waitstate
// Routes CPU accesses to 2**BANK_BITS banks selected by the top BANK_BITS address bits.
// Each bank gets a programmable wait-state count and can optionally stall on its external
// ready. Completes with a one-cycle ready pulse, registered read data and a bus_error
// flag for unmapped banks or external-ready timeouts.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   address, data_in      CPU address / write data (sampled only when idle)
//   bus_enable            CPU access request
//   write_enable          1 = write, 0 = read
//   data_out              registered read data
//   ready, bus_error      one-cycle completion pulse and its error qualifier
//   err_address           address of the most recent errored access
//   bank_address          latched in-bank address
//   bank_data_out         latched write data
//   bank_enable           one-hot bank select
//   bank_write_enable     one-hot write strobe
//   bank_data_in          packed per-bank read data, bank i at [i*DATA_WIDTH +: DATA_WIDTH]
//   bank_ready            per-bank external ready
module memory_bus_waitstate #(
   parameter int unsigned                  ADDR_WIDTH     = 16,
   parameter int unsigned                  DATA_WIDTH     = 8,
   parameter int unsigned                  BANK_BITS      = 2,
   parameter logic [(2**BANK_BITS)-1:0]    BANK_PRESENT   = 4'b1111,
   parameter logic [4*(2**BANK_BITS)-1:0]  BANK_WAIT      = 16'h1111,
   parameter logic [(2**BANK_BITS)-1:0]    BANK_EXT_READY = 4'b0000,
   parameter int unsigned                  TIMEOUT_CYCLES = 255
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [ADDR_WIDTH-1:0]               address,
   input  logic [DATA_WIDTH-1:0]               data_in,
   output logic [DATA_WIDTH-1:0]               data_out,
   input  logic                                bus_enable,
   input  logic                                write_enable,
   output logic                                ready,
   output logic                                bus_error,
   output logic [ADDR_WIDTH-1:0]               err_address,
   output logic [ADDR_WIDTH-BANK_BITS-1:0]     bank_address,
   output logic [DATA_WIDTH-1:0]               bank_data_out,
   output logic [(2**BANK_BITS)-1:0]           bank_enable,
   output logic [(2**BANK_BITS)-1:0]           bank_write_enable,
   input  logic [(2**BANK_BITS)*DATA_WIDTH-1:0] bank_data_in,
   input  logic [(2**BANK_BITS)-1:0]           bank_ready
);

   localparam int unsigned NB    = 2**BANK_BITS;
   localparam int unsigned IN_W  = ADDR_WIDTH - BANK_BITS;
   localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {StIdle, StAccess, StExtWait, StDone} state_e;

   state_e                 state_q, state_d;
   logic [BANK_BITS-1:0]   bank_q, bank_d;
   logic                   we_q, we_d;
   logic [3:0]             wait_q, wait_d;
   logic [TMO_W-1:0]       tmo_q, tmo_d;

   logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
   logic                   ready_q, ready_d;
   logic                   bus_error_q, bus_error_d;
   logic [ADDR_WIDTH-1:0]  err_address_q, err_address_d;
   logic [IN_W-1:0]        bank_address_q, bank_address_d;
   logic [DATA_WIDTH-1:0]  bank_data_out_q, bank_data_out_d;
   logic [NB-1:0]          bank_enable_q, bank_enable_d;
   logic [NB-1:0]          bank_write_enable_q, bank_write_enable_d;

   logic [BANK_BITS-1:0]   req_bank;
   logic [NB-1:0]          req_onehot;
   logic [3:0]             req_wait;
   logic [DATA_WIDTH-1:0]  rd_data;
   logic                   req_present;
   logic                   sel_ready;
   logic                   ext_req;
   logic                   complete;
   logic                   tmo_hit;

   assign req_bank    = address[ADDR_WIDTH-1 -: BANK_BITS];
   assign req_present = BANK_PRESENT[req_bank];
   assign sel_ready   = bank_ready[bank_q];
   assign ext_req     = BANK_EXT_READY[bank_q];

   // Per-bank decode of the requested bank and of the read data for the latched bank.
   always_comb begin
      req_onehot = '0;
      req_wait   = '0;
      rd_data    = '0;
      for (int i = 0; i < NB; i++) begin
         if (req_bank == BANK_BITS'(i)) begin
            req_onehot[i] = 1'b1;
            req_wait      = BANK_WAIT[4*i +: 4];
         end
         if (bank_q == BANK_BITS'(i)) begin
            rd_data = bank_data_in[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign complete = ((state_q == StAccess) && (wait_q == 4'd0) && (!ext_req || sel_ready))
                   || ((state_q == StExtWait) && sel_ready);

   // The counter is compared before incrementing, so EXT_WAIT lasts exactly TIMEOUT_CYCLES.
   assign tmo_hit = (state_q == StExtWait) && !sel_ready && (TIMEOUT_CYCLES != 0)
                  && (tmo_q == TMO_LIMIT - TMO_W'(1));

   // State register (plus datapath flops).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q             <= StIdle;
         bank_q              <= '0;
         we_q                <= 1'b0;
         wait_q              <= '0;
         tmo_q               <= '0;
         data_out_q          <= '0;
         ready_q             <= 1'b0;
         bus_error_q         <= 1'b0;
         err_address_q       <= '0;
         bank_address_q      <= '0;
         bank_data_out_q     <= '0;
         bank_enable_q       <= '0;
         bank_write_enable_q <= '0;
      end else begin
         state_q             <= state_d;
         bank_q              <= bank_d;
         we_q                <= we_d;
         wait_q              <= wait_d;
         tmo_q               <= tmo_d;
         data_out_q          <= data_out_d;
         ready_q             <= ready_d;
         bus_error_q         <= bus_error_d;
         err_address_q       <= err_address_d;
         bank_address_q      <= bank_address_d;
         bank_data_out_q     <= bank_data_out_d;
         bank_enable_q       <= bank_enable_d;
         bank_write_enable_q <= bank_write_enable_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      bank_d  = bank_q;
      we_d    = we_q;
      wait_d  = wait_q;
      tmo_d   = tmo_q;
      unique case (state_q)
         StIdle: begin
            if (bus_enable) begin
               bank_d = req_bank;
               we_d   = write_enable;
               if (!req_present) begin
                  state_d = StDone;
               end else begin
                  wait_d  = req_wait;
                  state_d = StAccess;
               end
            end
         end
         StAccess: begin
            if (wait_q != 4'd0) begin
               wait_d = wait_q - 4'd1;
            end else if (complete) begin
               state_d = StDone;
            end else begin
               state_d = StExtWait;
               tmo_d   = '0;
            end
         end
         StExtWait: begin
            if (complete || tmo_hit) begin
               state_d = StDone;
            end else if (tmo_q != '1) begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         StDone: begin
            // One access per request: wait for the CPU to drop bus_enable.
            if (!bus_enable) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Output logic (registered outputs' next values).
   always_comb begin
      data_out_d          = data_out_q;
      ready_d             = 1'b0;
      bus_error_d         = 1'b0;
      err_address_d       = err_address_q;
      bank_address_d      = bank_address_q;
      bank_data_out_d     = bank_data_out_q;
      bank_enable_d       = bank_enable_q;
      bank_write_enable_d = bank_write_enable_q;
      unique case (state_q)
         StIdle: begin
            if (bus_enable) begin
               bank_address_d  = address[IN_W-1:0];
               bank_data_out_d = data_in;
               if (!req_present) begin
                  ready_d       = 1'b1;
                  bus_error_d   = 1'b1;
                  data_out_d    = '0;
                  err_address_d = address;
               end else begin
                  bank_enable_d       = req_onehot;
                  bank_write_enable_d = write_enable ? req_onehot : '0;
               end
            end
         end
         StAccess, StExtWait: begin
            if (complete) begin
               ready_d             = 1'b1;
               bank_enable_d       = '0;
               bank_write_enable_d = '0;
               if (!we_q) data_out_d = rd_data;
            end else if (tmo_hit) begin
               ready_d             = 1'b1;
               bus_error_d         = 1'b1;
               data_out_d          = '0;
               err_address_d       = {bank_q, bank_address_q};
               bank_enable_d       = '0;
               bank_write_enable_d = '0;
            end
         end
         StDone: begin
         end
         default: begin
         end
      endcase
   end

   assign data_out          = data_out_q;
   assign ready             = ready_q;
   assign bus_error         = bus_error_q;
   assign err_address       = err_address_q;
   assign bank_address      = bank_address_q;
   assign bank_data_out     = bank_data_out_q;
   assign bank_enable       = bank_enable_q;
   assign bank_write_enable = bank_write_enable_q;

endmodule

// File: tb/tb_memory_bus_waitstate.sv
module tb_memory_bus_waitstate;
   localparam int AW = 16;
   localparam int DW = 8;
   localparam int NB = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [AW-1:0]    address;
   logic [DW-1:0]    data_in;
   logic             bus_enable, bus_enable_b, write_enable;
   logic [NB*DW-1:0] bank_data_in;
   logic [NB-1:0]    bank_ready, bank_ready_b;

   logic [DW-1:0]    data_out_a, data_out_b, bank_data_out_a, bank_data_out_b;
   logic             ready_a, ready_b, bus_error_a, bus_error_b;
   logic [AW-1:0]    err_address_a, err_address_b;
   logic [AW-3:0]    bank_address_a, bank_address_b;
   logic [NB-1:0]    bank_enable_a, bank_enable_b, bank_write_enable_a, bank_write_enable_b;

   // Bank 2 unmapped, bank 3 has 3 wait states, bank 1 waits on external ready.
   memory_bus_waitstate #(
      .ADDR_WIDTH(16), .DATA_WIDTH(8), .BANK_BITS(2), .BANK_PRESENT(4'b1011),
      .BANK_WAIT(16'h3111), .BANK_EXT_READY(4'b0010), .TIMEOUT_CYCLES(255)
   ) dut_a (
      .clk(clk), .reset(reset), .address(address), .data_in(data_in),
      .data_out(data_out_a), .bus_enable(bus_enable), .write_enable(write_enable),
      .ready(ready_a), .bus_error(bus_error_a), .err_address(err_address_a),
      .bank_address(bank_address_a), .bank_data_out(bank_data_out_a),
      .bank_enable(bank_enable_a), .bank_write_enable(bank_write_enable_a),
      .bank_data_in(bank_data_in), .bank_ready(bank_ready)
   );

   memory_bus_waitstate #(
      .ADDR_WIDTH(16), .DATA_WIDTH(8), .BANK_BITS(2), .BANK_PRESENT(4'b1011),
      .BANK_WAIT(16'h3111), .BANK_EXT_READY(4'b0010), .TIMEOUT_CYCLES(8)
   ) dut_b (
      .clk(clk), .reset(reset), .address(address), .data_in(data_in),
      .data_out(data_out_b), .bus_enable(bus_enable_b), .write_enable(write_enable),
      .ready(ready_b), .bus_error(bus_error_b), .err_address(err_address_b),
      .bank_address(bank_address_b), .bank_data_out(bank_data_out_b),
      .bank_enable(bank_enable_b), .bank_write_enable(bank_write_enable_b),
      .bank_data_in(bank_data_in), .bank_ready(bank_ready_b)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cnt_a, cnt_b, rdy_at;
   logic [31:0] cap_err, cap_ea, cap_do, cap_en;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   initial begin
      address = '0; data_in = '0; write_enable = 1'b0;
      bus_enable = 1'b0; bus_enable_b = 1'b0;
      bank_ready = '0; bank_ready_b = '0;
      bank_data_in = {8'h77, 8'h66, 8'h3C, 8'hA5};

      // Reset values
      #2;
      check("rst_strobes", {28'd0, bank_enable_a}, 32'd0);
      check("rst_flags", {ready_a, bus_error_a, bank_write_enable_a}, 32'd0);
      check("rst_data", {data_out_a, bank_data_out_a, err_address_a}, 32'd0);
      check("rst_baddr", {18'd0, bank_address_a}, 32'd0);
      tick; tick;
      reset = 1'b0;

      // Read bank 0, W=1
      address = 16'h0123; write_enable = 1'b0; bus_enable = 1'b1;
      tick; bus_enable = 1'b0;
      check("rd0_en", {28'd0, bank_enable_a}, 32'h1);
      check("rd0_baddr", {18'd0, bank_address_a}, 32'h123);
      check("rd0_rdy_early1", {31'd0, ready_a}, 32'd0);
      tick;
      check("rd0_rdy_early2", {31'd0, ready_a}, 32'd0);
      check("rd0_en_held", {28'd0, bank_enable_a}, 32'h1);
      tick;
      check("rd0_rdy", {31'd0, ready_a}, 32'd1);
      check("rd0_data", {24'd0, data_out_a}, 32'hA5);
      check("rd0_err", {31'd0, bus_error_a}, 32'd0);
      check("rd0_en_off", {28'd0, bank_enable_a}, 32'd0);
      tick;
      check("rd0_rdy_pulse", {31'd0, ready_a}, 32'd0);

      // Write bank 3, W=3
      address = 16'hC010; data_in = 8'h5A; write_enable = 1'b1; bus_enable = 1'b1;
      tick; bus_enable = 1'b0; write_enable = 1'b0;
      check("wr3_baddr", {18'd0, bank_address_a}, 32'h010);
      check("wr3_bdata", {24'd0, bank_data_out_a}, 32'h5A);
      check("wr3_en", {28'd0, bank_enable_a}, 32'h8);
      cnt_a = (bank_write_enable_a == 4'b1000) ? 1 : 0;
      cnt_b = 0; rdy_at = 0;
      for (int i = 2; i <= 10; i++) begin
         tick;
         if (bank_write_enable_a == 4'b1000) cnt_a++;
         if (ready_a) begin cnt_b++; rdy_at = i; end
      end
      check("wr3_we_cycles", cnt_a, 32'd4);
      check("wr3_rdy_count", cnt_b, 32'd1);
      check("wr3_rdy_tick", rdy_at, 32'd5);
      check("wr3_data_kept", {24'd0, data_out_a}, 32'hA5);

      // Unmapped bank 2
      address = 16'h8000; bus_enable = 1'b1;
      tick; bus_enable = 1'b0;
      check("um_rdy", {31'd0, ready_a}, 32'd1);
      check("um_err", {31'd0, bus_error_a}, 32'd1);
      check("um_eaddr", {16'd0, err_address_a}, 32'h8000);
      check("um_data", {24'd0, data_out_a}, 32'd0);
      check("um_strobes", {24'd0, bank_enable_a, bank_write_enable_a}, 32'd0);
      tick;
      check("um_pulse", {30'd0, ready_a, bus_error_a}, 32'd0);
      tick;

      // External ready on bank 1, released after a long stall
      address = 16'h4000; bus_enable = 1'b1;
      tick; bus_enable = 1'b0;
      check("ext_en", {28'd0, bank_enable_a}, 32'h2);
      cnt_a = 0;
      for (int i = 0; i < 12; i++) begin
         tick;
         if (bank_enable_a == 4'b0010 && !ready_a) cnt_a++;
      end
      check("ext_stall", cnt_a, 32'd12);
      bank_ready = 4'b0010;
      tick; bank_ready = '0;
      check("ext_rdy", {31'd0, ready_a}, 32'd1);
      check("ext_data", {24'd0, data_out_a}, 32'h3C);
      check("ext_err", {31'd0, bus_error_a}, 32'd0);
      tick;
      check("ext_pulse", {31'd0, ready_a}, 32'd0);

      // Timeout instance: prime data_out, then time out on bank 1
      address = 16'h0001; bus_enable_b = 1'b1;
      tick; bus_enable_b = 1'b0;
      tick; tick;
      check("tmo_prime", {23'd0, ready_b, data_out_b}, 32'h1A5);
      tick;
      address = 16'h4000; bus_enable_b = 1'b1;
      cnt_a = 0; cnt_b = 0; rdy_at = 0;
      cap_err = '0; cap_ea = '0; cap_do = '1; cap_en = '1;
      for (int i = 1; i <= 20; i++) begin
         tick;
         bus_enable_b = 1'b0;
         if (bank_enable_b == 4'b0010) cnt_a++;
         if (ready_b) begin
            cnt_b++;
            if (rdy_at == 0) begin
               rdy_at = i; cap_err = {31'd0, bus_error_b}; cap_ea = {16'd0, err_address_b};
               cap_do = {24'd0, data_out_b}; cap_en = {28'd0, bank_enable_b};
            end
         end
      end
      check("tmo_rdy_tick", rdy_at, 32'd11);
      check("tmo_rdy_count", cnt_b, 32'd1);
      check("tmo_held", cnt_a, 32'd10);
      check("tmo_err", cap_err, 32'd1);
      check("tmo_eaddr", cap_ea, 32'h4000);
      check("tmo_data", cap_do, 32'd0);
      check("tmo_en_off", cap_en, 32'd0);

      // bus_enable held for 20 cycles: one access only
      address = 16'h0123; bus_enable = 1'b1;
      cnt_a = 0; cnt_b = 0;
      for (int i = 0; i < 20; i++) begin
         tick;
         if (ready_a) cnt_a++;
         if (bank_enable_a != 4'b0000) cnt_b++;
      end
      check("hold_rdy_count", cnt_a, 32'd1);
      check("hold_en_cycles", cnt_b, 32'd2);
      bus_enable = 1'b0;
      tick;
      check("hold_idle", {28'd0, bank_enable_a}, 32'd0);
      address = 16'hC010; bus_enable = 1'b1;
      tick; bus_enable = 1'b0;
      check("hold_next_en", {28'd0, bank_enable_a}, 32'h8);
      tick; tick; tick; tick;
      check("hold_next_rdy", {31'd0, ready_a}, 32'd1);
      check("hold_next_data", {24'd0, data_out_a}, 32'h77);
      tick;

      // Reset while in EXT_WAIT
      address = 16'h4000; bus_enable = 1'b1;
      tick; bus_enable = 1'b0;
      tick; tick; tick; tick;
      check("rstx_en_before", {28'd0, bank_enable_a}, 32'h2);
      reset = 1'b1;
      #1;
      check("rstx_en_drop", {28'd0, bank_enable_a}, 32'd0);
      check("rstx_data", {24'd0, data_out_a}, 32'd0);
      tick; reset = 1'b0;
      cnt_a = 0;
      for (int i = 0; i < 5; i++) begin
         tick;
         if (ready_a) cnt_a++;
      end
      check("rstx_no_rdy", cnt_a, 32'd0);
      address = 16'h0123; bus_enable = 1'b1;
      tick; bus_enable = 1'b0;
      tick; tick;
      check("rstx_next_rdy", {31'd0, ready_a}, 32'd1);
      check("rstx_next_data", {24'd0, data_out_a}, 32'hA5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
